// File: rtl/fir_poly_seq.sv
// fir_poly_seq: sequencer and coefficient loader for the polyphase decimating FIR.
// Broadcasts the phase counter (tap_addr) and accumulate control to all M banks,
// streams N_TAPS coefficients into the per-bank memories in polyphase order, and
// flags the cycle in which the bank outputs carry a finished result.
module fir_poly_seq #(
  parameter int M             = 20,
  parameter int BANK_LEN      = 6,
  parameter int N_TAPS        = 120,
  parameter int TAP_WIDTH     = 16,
  parameter int CAPTURE_ADDR  = 8,
  parameter int M_LOG2        = $clog2(M),
  parameter int BANK_LEN_LOG2 = $clog2(BANK_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     load_start,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic [TAP_WIDTH-1:0]     coef_data,
  output logic                     coef_we,
  output logic [M_LOG2-1:0]        coef_wbank,
  output logic [BANK_LEN_LOG2-1:0] coef_waddr,
  output logic [TAP_WIDTH-1:0]     coef_wdata,
  output logic [M_LOG2-1:0]        tap_addr,
  output logic                     dsp_acc,
  output logic                     dout_valid,
  output logic                     taps_valid,
  output logic                     busy
);

  // Parameter sanity: the bank array geometry and capture point must be consistent.
  generate
    if (M * BANK_LEN != N_TAPS) begin : g_chk_taps
      $error("fir_poly_seq: M*BANK_LEN must equal N_TAPS");
    end
    if (CAPTURE_ADDR >= M - 1) begin : g_chk_cap_hi
      $error("fir_poly_seq: CAPTURE_ADDR must be below M-1");
    end
    if (BANK_LEN - 1 > CAPTURE_ADDR) begin : g_chk_cap_lo
      $error("fir_poly_seq: CAPTURE_ADDR must be at least BANK_LEN-1");
    end
  endgenerate

  localparam logic [M_LOG2-1:0]        TAP_LAST = M_LOG2'(M - 1);
  localparam logic [M_LOG2-1:0]        TAP_CAP  = M_LOG2'(CAPTURE_ADDR);
  localparam logic [M_LOG2-1:0]        BANK_LAST = M_LOG2'(M - 1);
  localparam logic [BANK_LEN_LOG2-1:0] IDX_LAST  = BANK_LEN_LOG2'(BANK_LEN - 1);
  localparam logic [BANK_LEN_LOG2-1:0] WARM_MAX  = BANK_LEN_LOG2'(BANK_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [M_LOG2-1:0]        bank_q;   // k mod M
  logic [BANK_LEN_LOG2-1:0] idx_q;    // k / M
  logic [BANK_LEN_LOG2-1:0] warm_q;   // completed frames since run start, saturating

  logic              accept;
  logic              last_beat;
  logic              tap_last;
  logic              counting;
  logic              tap_adv;
  logic [M_LOG2-1:0] tap_nx;

  assign accept    = (state == LOAD) && coef_valid && coef_ready;
  assign last_beat = accept && (bank_q == BANK_LAST) && (idx_q == IDX_LAST);
  assign tap_last  = (tap_addr == TAP_LAST);
  assign counting  = (state == RUN) || (state == STOP);

  // The phase counter only moves while a frame is in flight; any path back to
  // IDLE leaves it parked at M-1 so the banks neither shift nor capture.
  assign tap_adv = counting && (state_nx != IDLE);
  assign tap_nx  = !tap_adv ? TAP_LAST :
                   (tap_last ? '0 : tap_addr + M_LOG2'(1));

  // Write port is zero-latency: it follows the handshake and the load counters.
  assign coef_we    = accept;
  assign coef_wbank = bank_q;
  assign coef_waddr = idx_q;
  assign coef_wdata = coef_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic. A run that is told to stop finishes its frame first; a
  // frame that is already on its last phase stops immediately.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (load_start)              state_nx = LOAD;
        else if (en && taps_valid)   state_nx = RUN;
      end
      LOAD: begin
        if (!load_start && last_beat) state_nx = IDLE;
      end
      RUN: begin
        if (!en) state_nx = tap_last ? IDLE : STOP;
      end
      STOP: begin
        if (en)            state_nx = RUN;
        else if (tap_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame sequencer: phase counter, accumulate control, warm-up and output strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_addr   <= TAP_LAST;
      dsp_acc    <= 1'b0;
      warm_q     <= '0;
      dout_valid <= 1'b0;
    end else begin
      tap_addr   <= tap_nx;
      dsp_acc    <= tap_adv && (tap_nx != '0);
      dout_valid <= counting && (tap_addr == TAP_CAP) && (warm_q == WARM_MAX);
      // dsp_acc is low on the parked M-1 of a fresh run, so only genuine
      // end-of-frame wraps advance warm-up.
      if (state == IDLE && state_nx == RUN)
        warm_q <= '0;
      else if (tap_adv && tap_last && dsp_acc && warm_q != WARM_MAX)
        warm_q <= warm_q + BANK_LEN_LOG2'(1);
    end
  end

  // Load counters: bank is the inner counter, index the outer one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      idx_q  <= '0;
    end else if ((load_start && (state == IDLE || state == LOAD)) || last_beat) begin
      bank_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      if (bank_q == BANK_LAST) begin
        bank_q <= '0;
        idx_q  <= idx_q + BANK_LEN_LOG2'(1);
      end else begin
        bank_q <= bank_q + M_LOG2'(1);
      end
    end
  end

  // Registered status flags, derived from where the FSM is heading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_ready <= 1'b0;
      taps_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      coef_ready <= (state_nx == LOAD);
      busy       <= (state_nx != IDLE);
      if (state_nx == LOAD)
        taps_valid <= 1'b0;
      else if (last_beat)
        taps_valid <= 1'b1;
    end
  end

endmodule
